// File: rtl/onebitram_ctrl.sv
// Request/response controller for a bank of DEPTH one-bit RAM cells.
// Optional write read-back verification is enabled by defining RAM_VERIFY_EN.
module onebitram_ctrl #(
    parameter int DEPTH       = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int READ_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_data,
    output logic                  rsp_error,
    output logic [DEPTH-1:0]      cell_write_enable,
    output logic                  cell_write_data,
    output logic [DEPTH-1:0]      cell_read_enable,
    input  logic [DEPTH-1:0]      cell_read_data
);

    localparam int                  CNT_W    = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(READ_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    function automatic logic [DEPTH-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
        return {{(DEPTH - 1){1'b0}}, 1'b1} << a;
    endfunction

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_data_q, rsp_data_d;
    logic                    rsp_error_q, rsp_error_d;
    logic [DEPTH-1:0]        we_q, we_d;
    logic [DEPTH-1:0]        re_q, re_d;
    logic                    wd_q, wd_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    accept;
    logic                    in_range;
    logic                    rd_bit;
`ifdef RAM_VERIFY_EN
    logic                    wr_q;
    logic                    wdata_q;
`endif

    assign accept   = req_valid & req_ready_q;
    assign in_range = {1'b0, req_addr} < DEPTH_A;
    assign rd_bit   = |(cell_read_data & onehot(addr_q));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        we_d        = '0;
        re_d        = '0;
        wd_d        = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    req_ready_d = 1'b0;
                    if (!in_range) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 1'b0;
                        rsp_error_d = 1'b1;
                    end else if (req_write) begin
                        state_d = WRITE;
                        we_d    = onehot(req_addr);
                        wd_d    = req_wdata;
                    end else begin
                        state_d = READ;
                        re_d    = onehot(req_addr);
                        cnt_d   = '0;
                    end
                end
            end
            WRITE: begin
`ifdef RAM_VERIFY_EN
                state_d = READ;
                re_d    = onehot(addr_q);
                cnt_d   = '0;
`else
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = 1'b0;
                rsp_error_d = 1'b0;
`endif
            end
            READ: begin
                if (cnt_q == CNT_LAST) begin
                    // Strobe drops with the sample so it is high exactly READ_CYCLES cycles
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rd_bit;
`ifdef RAM_VERIFY_EN
                    rsp_error_d = wr_q & (rd_bit != wdata_q);
`else
                    rsp_error_d = 1'b0;
`endif
                end else begin
                    re_d  = re_q;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = 1'b0;
                    rsp_error_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 1'b0;
            rsp_error_q <= 1'b0;
            we_q        <= '0;
            re_q        <= '0;
            wd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            we_q        <= we_d;
            re_q        <= re_d;
            wd_q        <= wd_d;
        end
    end

    // Request payload is only meaningful once accepted, so it needs no reset
    always_ff @(posedge clock) begin
        if (accept) begin
            addr_q <= req_addr;
`ifdef RAM_VERIFY_EN
            wr_q    <= req_write;
            wdata_q <= req_wdata;
`endif
        end
    end

    assign req_ready         = req_ready_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_data          = rsp_data_q;
    assign rsp_error         = rsp_error_q;
    assign cell_write_enable = we_q;
    assign cell_write_data   = wd_q;
    assign cell_read_enable  = re_q;

endmodule
